// File: rtl/mdu_iterative.sv
// mdu_iterative: 32-cycle shift-add multiply / restoring divide unit
// holding the architectural HI/LO registers, with MTHI/MTLO writes.
module mdu_iterative #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   m;
   logic               sa;
   logic               sb;
   logic               is_div;
   logic               dz;

   logic               sgn_a;
   logic               sgn_b;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic               q_bit;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   always_comb begin
      sgn_a = ~op[0] & a[WIDTH-1];
      sgn_b = ~op[0] & b[WIDTH-1];
      mag_a = sgn_a ? -a : a;
      mag_b = sgn_b ? -b : b;
   end

   // mul: acc = {partial, multiplier}; div: acc = {remainder, dividend/quotient}
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, m};
      q_bit     = ~div_trial[WIDTH];
      div_rem   = q_bit ? div_trial[WIDTH-1:0]
                        : acc[2*WIDTH-2:WIDTH-1];
   end

   always_comb begin
      prod = (sa ^ sb) ? -acc : acc;
      quo  = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      if (dz) quo = '1;
      rem  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         m      <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         is_div <= 1'b0;
         dz     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= CALC;
                  busy   <= 1'b1;
                  cnt    <= CW'(WIDTH - 1);
                  sa     <= sgn_a;
                  sb     <= sgn_b;
                  is_div <= op[1];
                  dz     <= op[1] & (b == '0);
                  if (op[1]) begin
                     acc <= {{WIDTH{1'b0}}, mag_a};
                     m   <= mag_b;
                  end else begin
                     acc <= {{WIDTH{1'b0}}, mag_b};
                     m   <= mag_a;
                  end
               end else begin
                  if (mthi) hi <= wd;
                  if (mtlo) lo <= wd;
               end
            end
            CALC: begin
               if (is_div)
                  acc <= {div_rem, acc[WIDTH-2:0], q_bit};
               else
                  acc <= {mul_sum, acc[WIDTH-1:1]};
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= FIX;
            end
            FIX: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
               if (is_div) begin
                  hi <= rem;
                  lo <= quo;
               end else begin
                  hi <= prod[2*WIDTH-1:WIDTH];
                  lo <= prod[WIDTH-1:0];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: random and directed checks of mdu_iterative
// against a plain-arithmetic HI/LO reference model.
module tb_mdu_iterative;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wd;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   mdu_iterative #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wd    (wd),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [63:0] ref_result(input logic [1:0] o,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
      longint p;
      int     xs;
      int     ys;
      int     q;
      int     r;
      xs = x;
      ys = y;
      case (o)
         2'd0: begin
            p = longint'(xs) * longint'(ys);
            return p;
         end
         2'd1: return {32'h0, x} * {32'h0, y};
         2'd2: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
               return {32'h0, 32'h8000_0000};
            q = xs / ys;
            r = xs % ys;
            return {r, q};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   // Launch one op; optionally collide a move with start, or inject a
   // second start plus mthi while busy.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit mv_start,
                         input bit inject);
      logic [63:0] want;
      int lat;
      want  = ref_result(o, x, y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      mthi  = mv_start;
      wd    = 32'h1234_5678;
      @(negedge clk);
      start = 1'b0;
      mthi  = 1'b0;
      op    = 2'($urandom_range(0, 3));
      a     = $urandom;
      b     = $urandom;
      lat   = 0;
      while (!done && lat < 40) begin
         check("busy", {63'b0, busy}, 64'd1);
         check("hold", {hi, lo}, {exp_hi, exp_lo});
         if (inject && lat == 5) begin
            start = 1'b1;
            mthi  = 1'b1;
            wd    = 32'h1234_5678;
         end else begin
            start = 1'b0;
            mthi  = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      mthi  = 1'b0;
      check("latency", 64'(lat), 64'd33);
      check("done_busy", {62'b0, done, busy}, 64'b10);
      check("result", {hi, lo}, want);
      exp_hi = want[63:32];
      exp_lo = want[31:0];
      @(negedge clk);
      check("done_pulse", {63'b0, done}, 64'd0);
      check("idle_hold", {hi, lo}, {exp_hi, exp_lo});
   endtask

   task automatic move(input bit h, input bit l, input logic [31:0] v);
      mthi = h;
      mtlo = l;
      wd   = v;
      @(negedge clk);
      mthi = 1'b0;
      mtlo = 1'b0;
      wd   = $urandom;
      if (h) exp_hi = v;
      if (l) exp_lo = v;
      check("move", {hi, lo}, {exp_hi, exp_lo});
      check("move_done", {62'b0, done, busy}, 64'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 9));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 2'd0;
      a     = '0;
      b     = '0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      wd    = '0;
      repeat (2) @(negedge clk);
      check("reset", {30'b0, busy, done, hi, lo}, 64'd0);
      reset  = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);

      run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0);
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
      run_op(2'd3, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0);
      run_op(2'd3, 32'h0000_0007, 32'h0000_0000, 1'b0, 1'b0);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 1'b0);
      run_op(2'd1, 32'h0001_0001, 32'h0000_FFFF, 1'b0, 1'b1);
      move(1'b0, 1'b1, 32'hCAFE_F00D);
      move(1'b1, 1'b0, 32'h0BAD_BEEF);
      move(1'b1, 1'b1, 32'h5A5A_A5A5);
      run_op(2'd0, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b0);

      // reset 10 cycles into a divide
      start = 1'b1;
      op    = 2'd2;
      a     = 32'h0000_0064;
      b     = 32'h0000_0007;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_reset", {30'b0, busy, done, hi, lo}, 64'd0);
      exp_hi = '0;
      exp_lo = '0;
      for (int i = 0; i < 36; i++) begin
         check("no_done", {63'b0, done}, 64'd0);
         @(negedge clk);
      end
      run_op(2'd0, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         if (i % 7 == 3) move(1'($urandom), 1'b1, $urandom);
         run_op(2'($urandom_range(0, 3)), pick(), pick(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
